rf_wport_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order WB stage and the multi-cycle
//  MUL/DIV unit (MDU). Buffers MDU results in a small FIFO and gives WB priority, with a starvation
//  cap. Keeps a per-register busy scoreboard of outstanding MDU destinations for ID hazard stalls.

---
 rtl/rf_wport_arbiter_pkg.sv | 18 +
 rtl/rf_wport_fifo.sv | 48 ++++
 rtl/rf_wport_arbiter.sv | 132 +++++++++++++
 tb/tb_rf_wport_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter:
// write-bundle struct, arbiter FSM states, address/data widths.
package rf_wport_arbiter_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wport_fifo.sv
// Sync FIFO holding MDU results until they win the write port.
// Ports: clk, reset (async, active-low), push/din, pop/dout, full, empty.
module rf_wport_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the regfile write port between WB and buffered MDU results.
// WB has priority with a starvation cap; reg_busy tracks pending MDU dests.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_w_en,
  input  logic [RF_ADDR_W-1:0] wb_w_addr,
  input  logic [RF_DATA_W-1:0] wb_w_data,
  output logic                 wb_hold,
  input  logic                 mdu_valid,
  output logic                 mdu_ready,
  input  logic [RF_ADDR_W-1:0] mdu_addr,
  input  logic [RF_DATA_W-1:0] mdu_data,
  input  logic                 mdu_issue_en,
  input  logic [RF_ADDR_W-1:0] mdu_issue_addr,
  output logic [31:0]          reg_busy,
  output logic                 rf_w_en,
  output logic [RF_ADDR_W-1:0] rf_w_addr,
  output logic [RF_DATA_W-1:0] rf_w_data,
  output logic                 mdu_grant
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   busy_nxt;
  logic          wb_grant;
  logic          fifo_full, fifo_empty;
  logic          push;
  rf_wr_t        push_ent, head;
  logic [$bits(rf_wr_t)-1:0] head_raw;

  assign push_ent  = '{addr: mdu_addr, data: mdu_data};
  assign mdu_ready = ~fifo_full;
  assign push      = mdu_valid & mdu_ready;
  assign head      = rf_wr_t'(head_raw);

  rf_wport_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rf_wr_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_ent),
    .pop   (mdu_grant),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Grants are gated by reset so a live WB request cannot
  // reach the regfile while the block is held in reset.
  always_comb begin
    wb_grant  = 1'b0;
    mdu_grant = 1'b0;
    wb_hold   = 1'b0;
    state_nxt = state;
    cnt_nxt   = '0;
    unique case (state)
      ARB_NORMAL: begin
        if (reset && wb_w_en)
          wb_grant = 1'b1;
        else if (reset && !fifo_empty)
          mdu_grant = 1'b1;
        if (wb_grant && !fifo_empty) begin
          if (cnt == CW'(STARVE_MAX - 1))
            state_nxt = ARB_FORCE;
          else
            cnt_nxt = cnt + CW'(1);
        end
      end
      ARB_FORCE: begin
        wb_hold   = 1'b1;
        mdu_grant = reset & ~fifo_empty;
        state_nxt = ARB_NORMAL;
      end
      default: state_nxt = ARB_NORMAL;
    endcase
  end

  always_comb begin
    rf_w_addr = '0;
    rf_w_data = '0;
    unique case (1'b1)
      wb_grant: begin
        rf_w_addr = wb_w_addr;
        rf_w_data = wb_w_data;
      end
      mdu_grant: begin
        rf_w_addr = head.addr;
        rf_w_data = head.data;
      end
      default: ;
    endcase
    rf_w_en = (wb_grant | mdu_grant) & (rf_w_addr != '0);
  end

  // Set is applied after clear so a same-cycle issue wins.
  always_comb begin
    busy_nxt = reg_busy;
    if (mdu_grant)
      busy_nxt[rf_w_addr] = 1'b0;
    if (mdu_issue_en && mdu_issue_addr != '0)
      busy_nxt[mdu_issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ARB_NORMAL;
      cnt      <= '0;
      reg_busy <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      reg_busy <= busy_nxt;
    end
  end

  wb_no_waw_a: assert property (
    @(posedge clk) disable iff (!reset)
    !(wb_grant && reg_busy[wb_w_addr])
  );

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter (DEPTH=2, STARVE_MAX=4).
// Inputs change 1ns after posedge; outputs sampled 3ns after posedge.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_w_en;
  logic [4:0]  wb_w_addr;
  logic [31:0] wb_w_data;
  logic        wb_hold;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_issue_en;
  logic [4:0]  mdu_issue_addr;
  logic [31:0] reg_busy;
  logic        rf_w_en;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic        mdu_grant;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter #(
    .FIFO_DEPTH (2),
    .STARVE_MAX (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_w_en        (wb_w_en),
    .wb_w_addr      (wb_w_addr),
    .wb_w_data      (wb_w_data),
    .wb_hold        (wb_hold),
    .mdu_valid      (mdu_valid),
    .mdu_ready      (mdu_ready),
    .mdu_addr       (mdu_addr),
    .mdu_data       (mdu_data),
    .mdu_issue_en   (mdu_issue_en),
    .mdu_issue_addr (mdu_issue_addr),
    .reg_busy       (reg_busy),
    .rf_w_en        (rf_w_en),
    .rf_w_addr      (rf_w_addr),
    .rf_w_data      (rf_w_data),
    .mdu_grant      (mdu_grant)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] a,
                    input logic [31:0] d);
    wb_w_en   = en;
    wb_w_addr = a;
    wb_w_data = d;
  endtask

  task automatic mdu(input logic v, input logic [4:0] a,
                     input logic [31:0] d);
    mdu_valid = v;
    mdu_addr  = a;
    mdu_data  = d;
  endtask

  initial begin
    reset = 1'b0;
    wb(1'b1, 5'd3, 32'h55);
    mdu(1'b0, 5'd0, 32'h0);
    mdu_issue_en   = 1'b0;
    mdu_issue_addr = 5'd0;

    // T1 reset
    repeat (2) tick();
    #2;
    check("rst_en",    32'(rf_w_en),   32'd0);
    check("rst_addr",  32'(rf_w_addr), 32'd0);
    check("rst_data",  rf_w_data,      32'd0);
    check("rst_hold",  32'(wb_hold),   32'd0);
    check("rst_grant", 32'(mdu_grant), 32'd0);
    check("rst_ready", 32'(mdu_ready), 32'd1);
    check("rst_busy",  reg_busy,       32'd0);
    tick();
    reset = 1'b1;
    #2;
    check("rel_en",   32'(rf_w_en),   32'd1);
    check("rel_addr", 32'(rf_w_addr), 32'd3);
    check("rel_data", rf_w_data,      32'h55);

    // T2 WB only
    tick();
    wb(1'b1, 5'd5, 32'h1234);
    #2;
    check("wb_en",   32'(rf_w_en),   32'd1);
    check("wb_addr", 32'(rf_w_addr), 32'd5);
    check("wb_data", rf_w_data,      32'h1234);

    // T3 MDU path
    tick();
    wb(1'b0, 5'd0, 32'h0);
    mdu_issue_en = 1'b1; mdu_issue_addr = 5'd7;
    #2;
    check("iss_busy0", reg_busy, 32'd0);
    tick();
    mdu_issue_en = 1'b0;
    mdu(1'b1, 5'd7, 32'hDEADBEEF);
    #2;
    check("iss_busy1", reg_busy, 32'h80);
    check("no_thru",   32'(rf_w_en), 32'd0);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    #2;
    check("mdu_en",    32'(rf_w_en),   32'd1);
    check("mdu_addr",  32'(rf_w_addr), 32'd7);
    check("mdu_data",  rf_w_data,      32'hDEADBEEF);
    check("mdu_grant", 32'(mdu_grant), 32'd1);
    check("mdu_busy",  reg_busy,       32'h80);
    tick();
    #2;
    check("clr_busy", reg_busy,       32'd0);
    check("idle_en",  32'(rf_w_en),   32'd0);

    // T4 starvation
    tick();
    mdu(1'b1, 5'd10, 32'hA0A0);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wb(1'b1, 5'd4, 32'(100 + i));
      #2;
      check("stv_wb",    rf_w_data,      32'(100 + i));
      check("stv_hold0", 32'(wb_hold),   32'd0);
      check("stv_nogr",  32'(mdu_grant), 32'd0);
      tick();
    end
    wb(1'b1, 5'd4, 32'd200);
    #2;
    check("frc_hold",  32'(wb_hold),   32'd1);
    check("frc_grant", 32'(mdu_grant), 32'd1);
    check("frc_addr",  32'(rf_w_addr), 32'd10);
    check("frc_data",  rf_w_data,      32'hA0A0);
    tick();
    #2;
    check("res_hold", 32'(wb_hold),   32'd0);
    check("res_data", rf_w_data,      32'd200);
    check("res_nogr", 32'(mdu_grant), 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #2;
    check("stv_empty", 32'(rf_w_en), 32'd0);

    // T5 full / backpressure
    tick();
    wb(1'b1, 5'd4, 32'd300);
    mdu(1'b1, 5'd11, 32'd1);
    #2;
    check("bp_rdy0", 32'(mdu_ready), 32'd1);
    tick();
    mdu(1'b1, 5'd12, 32'd2);
    #2;
    check("bp_rdy1", 32'(mdu_ready), 32'd1);
    tick();
    mdu(1'b1, 5'd13, 32'd3);
    #2;
    check("bp_full", 32'(mdu_ready), 32'd0);
    check("bp_wb",   rf_w_data,      32'd300);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #2;
    check("bp_full2", 32'(mdu_ready), 32'd0);
    check("bp_pop1",  32'(rf_w_addr), 32'd11);
    check("bp_gnt1",  32'(mdu_grant), 32'd1);
    tick();
    #2;
    check("bp_rdy2", 32'(mdu_ready), 32'd1);
    check("bp_pop2", rf_w_data,      32'd2);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    #2;
    check("pp_rdy",  32'(mdu_ready), 32'd1);
    check("pp_pop3", rf_w_data,      32'd3);
    check("pp_addr", 32'(rf_w_addr), 32'd13);
    tick();
    #2;
    check("pp_empty", 32'(mdu_grant), 32'd0);

    // T6 corners: addr-0 entry
    tick();
    mdu(1'b1, 5'd0, 32'hFF);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    #2;
    check("z_grant", 32'(mdu_grant), 32'd1);
    check("z_en",    32'(rf_w_en),   32'd0);
    tick();
    #2;
    check("z_gone", 32'(mdu_grant), 32'd0);

    // same-cycle issue and commit of GR[9]
    tick();
    mdu(1'b1, 5'd9, 32'h99);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    mdu_issue_en = 1'b1; mdu_issue_addr = 5'd9;
    #2;
    check("sc_grant", 32'(mdu_grant), 32'd1);
    check("sc_addr",  32'(rf_w_addr), 32'd9);
    tick();
    mdu_issue_en = 1'b0;
    #2;
    check("sc_busy", reg_busy, 32'h200);

    // async reset with two entries queued
    tick();
    wb(1'b1, 5'd4, 32'd400);
    mdu(1'b1, 5'd20, 32'd20);
    mdu_issue_en = 1'b1; mdu_issue_addr = 5'd21;
    tick();
    mdu(1'b1, 5'd21, 32'd21);
    mdu_issue_en = 1'b0;
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    #2;
    check("ar_full", 32'(mdu_ready), 32'd0);
    check("ar_busy", reg_busy, 32'h0020_0200);
    reset = 1'b0;
    #1;
    check("ar_rdy",   32'(mdu_ready), 32'd1);
    check("ar_clr",   reg_busy,       32'd0);
    check("ar_en",    32'(rf_w_en),   32'd0);
    tick();
    reset = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    #2;
    check("ar_empty", 32'(mdu_grant), 32'd0);
    check("ar_noen",  32'(rf_w_en),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
